// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: widths, opcodes, buffer entry layout
// and the writeback forwarding rules used at capture and on held entries.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int OPW  = 5;

  localparam logic [OPW-1:0] ALU_ADD   = 5'b00000;
  localparam logic [OPW-1:0] ALU_DIV   = 5'b01101;
  localparam logic [OPW-1:0] ALU_PASSB = 5'b10101;
  localparam logic [OPW-1:0] OP_MAX    = ALU_PASSB;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [OPW-1:0]  alu_op;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic            a_is_pc;
    logic            b_is_imm;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
  } issue_entry_t;

  // Register x0 is hardwired, so it never takes a forwarded value.
  function automatic logic fwd_hit(input logic           fwd_valid,
                                   input logic [RAW-1:0] fwd_rd,
                                   input logic [RAW-1:0] src);
    return fwd_valid && (fwd_rd != '0) && (fwd_rd == src);
  endfunction

  // Only register-sourced operands are refreshed; PC and immediate operands stay.
  function automatic issue_entry_t apply_fwd(input issue_entry_t    e,
                                             input logic            fwd_valid,
                                             input logic [RAW-1:0]  fwd_rd,
                                             input logic [XLEN-1:0] fwd_data);
    issue_entry_t r;
    r = e;
    if (!e.a_is_pc && fwd_hit(fwd_valid, fwd_rd, e.rs1)) r.ra = fwd_data;
    if (!e.b_is_imm && fwd_hit(fwd_valid, fwd_rd, e.rs2)) r.rb = fwd_data;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_entry.sv
// One buffer slot of the issue stage: loads a captured micro-op and keeps its
// register operands current with writeback results while it waits.
module alu_issue_entry
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d_i,
  input  logic            load_i,
  input  issue_entry_t    data_i,
  input  logic            leave_i,
  input  logic            fwd_valid_i,
  input  logic [RAW-1:0]  fwd_rd_i,
  input  logic [XLEN-1:0] fwd_data_i,
  output issue_entry_t    data_o
);

  logic         valid_q;
  issue_entry_t data_q;
  issue_entry_t data_d;

  // An entry leaving this cycle is not refreshed; its slot is reloaded or emptied.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (valid_q && !leave_i) begin
      data_d = apply_fwd(data_q, fwd_valid_i, fwd_rd_i, fwd_data_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d_i;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 32-bit ALU: operand select, writeback forwarding
// and a two-entry skid buffer between decode and execute.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_alu_op,
  input  logic [RAW-1:0]  in_rs1,
  input  logic [RAW-1:0]  in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_a_is_pc,
  input  logic            in_b_is_imm,
  input  logic [RAW-1:0]  in_rd,
  input  logic            fwd_valid,
  input  logic [RAW-1:0]  fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ra,
  output logic [XLEN-1:0] out_rb,
  output logic [OPW-1:0]  out_alu_op,
  output logic [RAW-1:0]  out_rd,
  output logic            out_illegal,
  output logic            out_div_zero,
  output issue_state_e    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and in_ready is a register (no path from
  // out_ready), so back-pressure is absorbed by the SKID entry.

  issue_state_e state_q, state_d;
  logic         in_ready_q;
  logic         accept, deliver;
  logic         main_load, main_from_skid, skid_load;
  issue_entry_t cap, main_in, main_q, skid_q;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid && out_ready;

  always_comb begin
    cap          = '0;
    cap.alu_op   = in_alu_op;
    cap.rd       = in_rd;
    cap.rs1      = in_rs1;
    cap.rs2      = in_rs2;
    cap.a_is_pc  = in_a_is_pc;
    cap.b_is_imm = in_b_is_imm;
    cap.ra       = in_a_is_pc ? in_pc
                 : (fwd_hit(fwd_valid, fwd_rd, in_rs1) ? fwd_data : in_rs1_val);
    cap.rb       = in_b_is_imm ? in_imm
                 : (fwd_hit(fwd_valid, fwd_rd, in_rs2) ? fwd_data : in_rs2_val);
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !deliver) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (deliver && !accept) begin
            state_d = ST_EMPTY;
          end else if (deliver && accept) begin
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // SKID picks up this cycle's writeback on its way into MAIN.
  assign main_in = main_from_skid ? apply_fwd(skid_q, fwd_valid, fwd_rd, fwd_data) : cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  alu_issue_entry u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_d_i  (state_d != ST_EMPTY),
    .load_i     (main_load),
    .data_i     (main_in),
    .leave_i    (deliver),
    .fwd_valid_i(fwd_valid),
    .fwd_rd_i   (fwd_rd),
    .fwd_data_i (fwd_data),
    .data_o     (main_q)
  );

  alu_issue_entry u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_d_i  (state_d == ST_FULL),
    .load_i     (skid_load),
    .data_i     (cap),
    .leave_i    (1'b0),
    .fwd_valid_i(fwd_valid),
    .fwd_rd_i   (fwd_rd),
    .fwd_data_i (fwd_data),
    .data_o     (skid_q)
  );

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_ra       = main_q.ra;
  assign out_rb       = main_q.rb;
  assign out_alu_op   = main_q.alu_op;
  assign out_rd       = main_q.rd;
  assign out_illegal  = out_valid && (main_q.alu_op > OP_MAX);
  assign out_div_zero = out_valid && (main_q.alu_op == ALU_DIV) && (main_q.rb == '0);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table for operand select/forwarding/flags,
// plus stall, held-forward, flush and async-reset sequences, all against a queue model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_alu_op, in_rs1, in_rs2, in_rd, fwd_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, fwd_data;
  logic        in_a_is_pc, in_b_is_imm, fwd_valid;
  logic        out_valid, out_ready, out_illegal, out_div_zero;
  logic [31:0] out_ra, out_rb;
  logic [4:0]  out_alu_op, out_rd;
  issue_state_e dbg_state;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_pc(in_pc), .in_a_is_pc(in_a_is_pc), .in_b_is_imm(in_b_is_imm),
    .in_rd(in_rd), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ra(out_ra), .out_rb(out_rb),
    .out_alu_op(out_alu_op), .out_rd(out_rd), .out_illegal(out_illegal),
    .out_div_zero(out_div_zero), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        a_pc, b_imm;
    logic [31:0] ra, rb;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   delivered = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic bound_expired(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic exp_t model_capture();
    exp_t        e;
    logic [31:0] v1, v2;
    v1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs1) ? fwd_data : in_rs1_val;
    v2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_rs2) ? fwd_data : in_rs2_val;
    e.op    = in_alu_op;
    e.rd    = in_rd;
    e.rs1   = in_rs1;
    e.rs2   = in_rs2;
    e.a_pc  = in_a_is_pc;
    e.b_imm = in_b_is_imm;
    e.ra    = in_a_is_pc ? in_pc : v1;
    e.rb    = in_b_is_imm ? in_imm : v2;
    return e;
  endfunction

  // Scoreboard: inputs settle 1ns after the rising edge, so on the falling edge
  // the handshake signals show exactly what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("occupancy_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      check("occupancy_in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            bound_expired("unexpected_delivery");
          end else begin
            m_e = exp_q.pop_front();
            delivered++;
            check("sb_ra", out_ra, m_e.ra);
            check("sb_rb", out_rb, m_e.rb);
            check("sb_op", {27'd0, out_alu_op}, {27'd0, m_e.op});
            check("sb_rd", {27'd0, out_rd}, {27'd0, m_e.rd});
            check("sb_illegal", {31'd0, out_illegal}, {31'd0, m_e.op > 5'b10101});
            check("sb_div_zero", {31'd0, out_div_zero},
                  {31'd0, (m_e.op == 5'b01101) && (m_e.rb == 32'd0)});
          end
        end
        if (fwd_valid && fwd_rd != 5'd0) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            m_e = exp_q[i];
            if (!m_e.a_pc && m_e.rs1 == fwd_rd) m_e.ra = fwd_data;
            if (!m_e.b_imm && m_e.rs2 == fwd_rd) m_e.rb = fwd_data;
            exp_q[i] = m_e;
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model_capture());
      end
    end
  end

  task automatic set_op(input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic apc, input logic bimm);
    in_alu_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_pc = pc;
    in_a_is_pc = apc; in_b_is_imm = bimm;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that accepted.
  task automatic wait_accept(input string name);
    int n;
    n = 0;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        bound_expired(name);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rs1, rs2;
    logic [31:0] v1, v2, imm, pc;
    logic        apc, bimm, fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
    logic [31:0] ra, rb;
    logic        ill, dz;
  } vec_t;

  vec_t vecs[11];
  int   d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
    set_op(5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    //          op        rs1 rs2  v1        v2        imm           pc        apc bimm fv frd fdata         ra            rb           ill dz
    vecs[0]  = '{5'b00000, 5'd1, 5'd2, 32'd5,     32'd7,    32'd0,        32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 32'd0,        32'd5,        32'd7,       1'b0, 1'b0};
    vecs[1]  = '{5'b00001, 5'd3, 5'd2, 32'h11,    32'h22,   32'd0,        32'd0,     1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22,      1'b0, 1'b0};
    vecs[2]  = '{5'b00001, 5'd0, 5'd2, 32'h33,    32'h44,   32'd0,        32'd0,     1'b0, 1'b0, 1'b1, 5'd0, 32'hCAFE,     32'h33,       32'h44,      1'b0, 1'b0};
    vecs[3]  = '{5'b00010, 5'd5, 5'd5, 32'hAAAA,  32'hBBBB, 32'hFFFFFFFC, 32'h100,   1'b1, 1'b1, 1'b1, 5'd5, 32'h1234,     32'h100,      32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[4]  = '{5'b01101, 5'd1, 5'd2, 32'd8,     32'd0,    32'd0,        32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 32'd0,        32'd8,        32'd0,       1'b0, 1'b1};
    vecs[5]  = '{5'b01101, 5'd1, 5'd6, 32'd8,     32'd3,    32'd0,        32'd0,     1'b0, 1'b0, 1'b1, 5'd6, 32'd0,        32'd8,        32'd0,       1'b0, 1'b1};
    vecs[6]  = '{5'b10110, 5'd1, 5'd2, 32'd1,     32'd2,    32'd0,        32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 32'd0,        32'd1,        32'd2,       1'b1, 1'b0};
    vecs[7]  = '{5'b10101, 5'd1, 5'd2, 32'd1,     32'd2,    32'd0,        32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 32'd0,        32'd1,        32'd2,       1'b0, 1'b0};
    vecs[8]  = '{5'b01101, 5'd1, 5'd2, 32'd8,     32'd5,    32'd0,        32'd0,     1'b0, 1'b0, 1'b0, 5'd0, 32'd0,        32'd8,        32'd5,       1'b0, 1'b0};
    vecs[9]  = '{5'b00011, 5'd1, 5'd7, 32'd1,     32'd2,    32'd0,        32'd0,     1'b0, 1'b0, 1'b1, 5'd7, 32'h55,       32'd1,        32'h55,      1'b0, 1'b0};
    vecs[10] = '{5'b01101, 5'd1, 5'd2, 32'd4,     32'd9,    32'd0,        32'd0,     1'b0, 1'b1, 1'b0, 5'd0, 32'd0,        32'd4,        32'd0,       1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_ra", out_ra, 32'd0);
    check("reset_out_div_zero", {31'd0, out_div_zero}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Vector table: one op at a time with execute always ready.
    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i].op, 5'(i + 1), vecs[i].rs1, vecs[i].rs2, vecs[i].v1, vecs[i].v2,
             vecs[i].imm, vecs[i].pc, vecs[i].apc, vecs[i].bimm);
      fwd_valid = vecs[i].fv; fwd_rd = vecs[i].frd; fwd_data = vecs[i].fdata;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; fwd_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_ra", i), out_ra, vecs[i].ra);
      check($sformatf("vec%0d_rb", i), out_rb, vecs[i].rb);
      check($sformatf("vec%0d_op", i), {27'd0, out_alu_op}, {27'd0, vecs[i].op});
      check($sformatf("vec%0d_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      check($sformatf("vec%0d_div_zero", i), {31'd0, out_div_zero}, {31'd0, vecs[i].dz});
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      idle(1);
    end

    // Back-pressure: two ops fill the buffer, the third waits for a slot.
    out_ready = 1'b0;
    d0 = delivered;
    set_op(5'd1, 5'd11, 5'd1, 5'd2, 32'h101, 32'h201, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("stall_op1");
    set_op(5'd2, 5'd12, 5'd1, 5'd2, 32'h102, 32'h202, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("stall_op2");
    set_op(5'd3, 5'd13, 5'd1, 5'd2, 32'h103, 32'h203, 32'd0, 32'd0, 1'b0, 1'b0);
    in_valid = 1'b1;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head_ra", out_ra, 32'h101);
    idle(2);
    check("full_held_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_held_rd", {27'd0, out_rd}, 32'd11);
    out_ready = 1'b1;
    wait_accept("stall_op3");
    idle(5);
    check("stall_delivered_count", delivered - d0, 32'd3);
    check("stall_queue_empty", exp_q.size(), 32'd0);

    // Held entries pick up writeback; PC/immediate operands must not.
    out_ready = 1'b0;
    set_op(5'd4, 5'd14, 5'd1, 5'd4, 32'h10, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("hold_op_x");
    set_op(5'd5, 5'd15, 5'd4, 5'd4, 32'h77, 32'h78, 32'h30, 32'h200, 1'b1, 1'b1);
    wait_accept("hold_op_y");
    fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'd9;
    idle(1);
    fwd_valid = 1'b0;
    check("held_fwd_rb", out_rb, 32'd9);
    check("held_fwd_ra_kept", out_ra, 32'h10);
    out_ready = 1'b1;
    idle(4);
    check("hold_queue_empty", exp_q.size(), 32'd0);

    // Flush while FULL with a new op offered in the same cycle.
    out_ready = 1'b0;
    set_op(5'd6, 5'd16, 5'd1, 5'd2, 32'h61, 32'h62, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("flush_fill1");
    set_op(5'd7, 5'd17, 5'd1, 5'd2, 32'h71, 32'h72, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("flush_fill2");
    set_op(5'd8, 5'd18, 5'd1, 5'd2, 32'h81, 32'h82, 32'd0, 32'd0, 1'b0, 1'b0);
    in_valid = 1'b1; flush = 1'b1;
    idle(1);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    set_op(5'd9, 5'd19, 5'd1, 5'd2, 32'h91, 32'h92, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("post_flush_op");
    check("post_flush_ra", out_ra, 32'h91);
    idle(3);

    // Asynchronous reset in the middle of a stalled stream.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_op(5'($urandom_range(1, 20)), 5'(20 + k), 5'd1, 5'd2,
             32'($urandom_range(1, 1000)), 32'($urandom_range(1, 1000)),
             32'd0, 32'd0, 1'b0, 1'b0);
      wait_accept("reset_fill");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_out_ra", out_ra, 32'd0);
    check("async_reset_out_rb", out_rb, 32'd0);
    check("async_reset_out_op", {27'd0, out_alu_op}, 32'd0);
    check("async_reset_out_rd", {27'd0, out_rd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    check("after_reset_in_ready", {31'd0, in_ready}, 32'd1);
    set_op(5'd10, 5'd30, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_accept("after_reset_op");
    idle(3);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Issue stage that sits directly upstream of the 32-bit custom ALU. It accepts decoded ALU micro-ops from decode through a valid/ready handshake. For each micro-op it selects operands (register, immediate or PC), applies result forwarding from writeback, and buffers up to two micro-ops in a skid buffer. It presents RA/RB/ALU_OP plus sideband flags to the execute stage through a second valid/ready handshake.

Parameters:
XLEN, 32, operand/result width
RAW, 5, register index width
OP_MAX, 5'b10101, highest legal ALU opcode

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  decode has a micro-op
in_ready  out  1  stage can accept
in_alu_op  in  5  ALU opcode
in_rs1  in  RAW  source 1 index
in_rs2  in  RAW  source 2 index
in_rs1_val  in  XLEN  register-file value for rs1
in_rs2_val  in  XLEN  register-file value for rs2
in_imm  in  XLEN  sign-extended immediate
in_pc  in  XLEN  instruction PC
in_a_is_pc  in  1  operand A = PC
in_b_is_imm  in  1  operand B = immediate
in_rd  in  RAW  destination index
fwd_valid  in  1  writeback result valid this cycle
fwd_rd  in  RAW  writeback destination
fwd_data  in  XLEN  writeback data
out_valid  out  1  micro-op presented to execute
out_ready  in  1  execute accepts
out_ra  out  XLEN  ALU RA
out_rb  out  XLEN  ALU RB
out_alu_op  out  5  ALU opcode
out_rd  out  RAW  destination index
out_illegal  out  1  opcode > OP_MAX
out_div_zero  out  1  opcode 5'b01101 with out_rb == 0

Behaviour:
- Reset: asynchronous, active-low. All outputs clear to 0 and both buffer entries become invalid. in_ready is 1 after reset release.
- Storage: two entries, MAIN (drives out_*) and SKID. Each entry holds alu_op, rd, rs1, rs2, a_is_pc, b_is_imm, ra, rb.
- States: EMPTY, ONE (MAIN valid), FULL (MAIN+SKID valid). out_valid = state != EMPTY. in_ready = state != FULL; it is registered, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
- EMPTY: on accept go to ONE, loading MAIN.
- ONE: accept without deliver goes to FULL, loading SKID. Deliver without accept goes to EMPTY. Accept and deliver together stay in ONE and reload MAIN from the input.
- FULL: on deliver, SKID moves to MAIN and the state becomes ONE. No accept is possible in FULL.
- Order is strictly FIFO; zero bubbles at full throughput (1 op/cycle).
- Operand select at capture: ra = in_a_is_pc ? in_pc : rs1 value; rb = in_b_is_imm ? in_imm : rs2 value.
- Forwarding at capture: the rs1 value is fwd_data when fwd_valid, fwd_rd != 0 and fwd_rd == in_rs1; otherwise it is in_rs1_val. rs2 follows the same rule.
- Forwarding on held entries: each cycle, any valid entry whose register-sourced operand matches fwd_rd (fwd_rd != 0, fwd_valid) overwrites that operand with fwd_data. An entry being delivered this cycle is not updated.
- Index 0 never forwards.
- out_illegal and out_div_zero are combinational from MAIN. Illegal ops still flow; execute decides what to do with them.
- flush: synchronous and highest priority. Next cycle the state is EMPTY and in_ready = 1. An accept in the flush cycle is discarded, and out_valid drops the next cycle.
- Held outputs: while out_valid & !out_ready, out_* stay stable except for forwarding operand updates.
- Reset asserted mid-transfer discards all entries immediately.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (ALU_ADD=5'b00000 … ALU_PASSB=5'b10101, ALU_DIV=5'b01101)
  - OP_MAX
  - the entry struct/field widths.
- One natural sub-module: alu_issue_entry, a single buffer entry with load, forward-update and valid logic, instantiated twice.

Test Plan:
- Reset, then accept one ADD with rs1_val=5, rs2_val=7, out_ready=1. Required: out_valid the next cycle with out_ra=5, out_rb=7, out_alu_op=0; in_ready stays 1.
- Hold out_ready=0 and present 3 ops. Required: ops 1 and 2 accepted, then in_ready=0 (FULL). Release out_ready: the ops deliver in order 1, 2, 3 with no duplicates and no loss.
- Accept op with rs1=3 while fwd_valid, fwd_rd=3, fwd_data=0xDEADBEEF. Required: out_ra=0xDEADBEEF.
  - Repeat with fwd_rd=0. Required: in_rs1_val is used.
  - A held entry stalled with rs2=4 receives fwd_rd=4, fwd_data=9. Required: its rb becomes 9.
- Send in_a_is_pc=1, in_pc=0x100, in_b_is_imm=1, in_imm=0xFFFFFFFC. Required: out_ra=0x100, out_rb=0xFFFFFFFC, and forwarding is ignored even when fwd_rd matches.
- Send op=5'b01101 with rb=0. Required: out_div_zero=1.
  - Send op=5'b10110. Required: out_illegal=1.
  - Send op=5'b10101. Required: out_illegal=0.
- In FULL state, assert flush together with in_valid. Required: next cycle out_valid=0 and in_ready=1. Drop rst_n asynchronously mid-stream. Required: outputs are 0 before the next clock edge.
